// File: rtl/sb_pkg.sv
// Shared types and constants for the sideband transmit/receive path.
// The byte-wide CRC step is also used by the receive-side checker.
package sb_pkg;

  typedef enum logic [3:0] {
    DISCONNECT, IDLE, DLE1, STX, LSE, CLSE, ADDR, LEN,
    DATA, STUFF, CRC_H, CRC_L, DLE2, ETX
  } sb_state_e;

  typedef enum logic [2:0] {
    REQ_LT     = 3'd0,
    REQ_RD_CMD = 3'd1,
    REQ_WR_CMD = 3'd2,
    REQ_RD_RSP = 3'd3,
    REQ_WR_RSP = 3'd4
  } req_type_e;

  localparam logic [7:0]  DLE_SYM  = 8'hFE;
  localparam logic [7:0]  STX_CMD  = 8'hA0;
  localparam logic [7:0]  STX_RSP  = 8'h20;
  localparam logic [7:0]  ETX_SYM  = 8'h40;
  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // MSB-first, non-reflected, no final xor.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      c = (c[15] ^ data[i]) ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/sb_crc16.sv
// CRC-16 accumulator: synchronous init to CRC_INIT, byte update on en_i.
// init_i wins over en_i.
module sb_crc16
  import sb_pkg::*;
(
  input  logic        sb_clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i)    crc_d = CRC_INIT;
    else if (en_i) crc_d = crc16_byte(crc_q, data_i);
  end

  always_ff @(posedge sb_clk_i or negedge rst_i) begin
    if (!rst_i) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sb_trans_gen.sv
// USB4 sideband transaction generator: LT and AT framing with inline CRC-16
// and DLE stuffing, one 10-bit frame held for SYM_CYCLES clocks.
//
// state      | meaning
// DISCONNECT | link down, trans = 0
// IDLE       | trans = 3FF, ready for a request
// DLE1       | leading DLE
// STX        | AT start symbol (command/response)
// LSE / CLSE | LT lane-state byte and its complement
// ADDR, LEN  | AT header bytes
// DATA       | payload byte byte_idx
// STUFF      | extra DLE after a data-class byte equal to DLE
// CRC_H/L    | CRC high then low byte
// DLE2, ETX  | AT trailer
module sb_trans_gen
  import sb_pkg::*;
#(
  parameter int MAX_DATA_BYTES = 16,
  parameter int SYM_CYCLES     = 8,
  parameter int LEN_W          = 7
) (
  input  logic                        sb_clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_type,
  input  logic [7:0]                  req_addr,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        req_lse,
  input  logic [MAX_DATA_BYTES*8-1:0] payload,
  input  logic                        disconnect_sbtx,
  input  logic                        tdisconnect_tx_min,
  output logic [9:0]                  trans,
  output logic                        trans_sent,
  output logic                        req_err,
  output logic                        disconnected_s
);

  localparam int SYM_W = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int IDX_W = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYM_CYCLES - 1);
  localparam logic [SYM_W-1:0] SYM_PRE  = SYM_W'(SYM_CYCLES - 2);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_DATA_BYTES);

  sb_state_e        state_q, state_d, goto_s, ret_q;
  req_type_e        type_q;
  logic [7:0]       addr_q;
  logic [LEN_W-1:0] len_q, byte_idx_q, idx_d;
  logic             lse_q;
  logic [SYM_W-1:0] sym_cnt_q;
  logic [9:0]       trans_q;
  logic             ready_q, sent_q, err_q;
  logic [7:0]       buf_q [MAX_DATA_BYTES];

  logic        discon, sym_last, tx_state, stuff_req;
  logic        is_cmd, is_wr, has_data, req_illegal, accept;
  logic        crc_init, crc_en;
  logic [7:0]  nxt_byte, lse_byte, len_byte;
  logic [15:0] crc;

  assign discon      = disconnect_sbtx && !tdisconnect_tx_min;
  assign sym_last    = (sym_cnt_q == SYM_LAST);
  assign tx_state    = (state_q != IDLE) && (state_q != DISCONNECT);
  assign is_cmd      = type_q inside {REQ_RD_CMD, REQ_WR_CMD};
  assign is_wr       = type_q inside {REQ_WR_CMD, REQ_WR_RSP};
  assign has_data    = type_q inside {REQ_WR_CMD, REQ_RD_RSP};
  assign lse_byte    = {4'b0000, lse_q, 3'b010};
  assign len_byte    = {is_wr, has_data ? 7'(len_q) : 7'd0};
  assign stuff_req   = (state_q inside {ADDR, LEN, DATA, CRC_H, CRC_L}) && (trans_q[8:1] == DLE_SYM);

  assign req_illegal = (req_type > 3'd4) ||
                       ((req_type == 3'd2 || req_type == 3'd3) &&
                        (req_len == '0 || req_len > MAX_LEN));
  assign accept      = (state_q == IDLE) && req_valid && ready_q && !discon && !req_illegal;

  always_comb begin
    goto_s = state_q;
    idx_d  = byte_idx_q;
    case (state_q)
      DLE1:      goto_s = (type_q == REQ_LT) ? LSE : STX;
      LSE:       goto_s = CLSE;
      CLSE, ETX: goto_s = IDLE;
      STX:       goto_s = ADDR;
      ADDR:      goto_s = LEN;
      LEN:       goto_s = has_data ? DATA : CRC_H;
      DATA: begin
        if (byte_idx_q == len_q - LEN_W'(1)) begin
          goto_s = CRC_H;
          idx_d  = '0;
        end else begin
          goto_s = DATA;
          idx_d  = byte_idx_q + LEN_W'(1);
        end
      end
      STUFF:     goto_s = ret_q;
      CRC_H:     goto_s = CRC_L;
      CRC_L:     goto_s = DLE2;
      DLE2:      goto_s = ETX;
      default:   goto_s = state_q;
    endcase
    state_d = stuff_req ? STUFF : goto_s;
  end

  always_comb begin
    nxt_byte = 8'hFF;
    case (state_d)
      DLE1, STUFF, DLE2: nxt_byte = DLE_SYM;
      STX:               nxt_byte = is_cmd ? STX_CMD : STX_RSP;
      LSE:               nxt_byte = lse_byte;
      CLSE:              nxt_byte = ~lse_byte;
      ADDR:              nxt_byte = addr_q;
      LEN:               nxt_byte = len_byte;
      DATA:              nxt_byte = buf_q[idx_d[IDX_W-1:0]];
      CRC_H:             nxt_byte = crc[15:8];
      CRC_L:             nxt_byte = crc[7:0];
      ETX:               nxt_byte = ETX_SYM;
      default:           nxt_byte = 8'hFF;
    endcase
  end

  // CRC covers a byte as it is launched, so CRC_H sees the full sum.
  assign crc_init = accept;
  assign crc_en   = tx_state && sym_last && !discon && (state_d inside {STX, ADDR, LEN, DATA});

  sb_crc16 u_crc (
    .sb_clk_i (sb_clk),
    .rst_i    (rst),
    .init_i   (crc_init),
    .en_i     (crc_en),
    .data_i   (nxt_byte),
    .crc_o    (crc)
  );

  always_ff @(posedge sb_clk) begin
    if (accept) begin
      for (int i = 0; i < MAX_DATA_BYTES; i++) buf_q[i] <= payload[8*i +: 8];
    end
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DISCONNECT;
      ret_q      <= DISCONNECT;
      type_q     <= REQ_LT;
      addr_q     <= '0;
      len_q      <= '0;
      lse_q      <= 1'b0;
      byte_idx_q <= '0;
      sym_cnt_q  <= '0;
      trans_q    <= '0;
      ready_q    <= 1'b0;
      sent_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sent_q <= 1'b0;
      err_q  <= 1'b0;
      if (discon && state_q != DISCONNECT) begin
        state_q    <= DISCONNECT;
        trans_q    <= '0;
        ready_q    <= 1'b0;
        sym_cnt_q  <= '0;
        byte_idx_q <= '0;
      end else begin
        case (state_q)
          DISCONNECT: begin
            if (!discon) begin
              state_q <= IDLE;
              trans_q <= 10'h3FF;
              ready_q <= 1'b1;
            end
          end
          IDLE: begin
            byte_idx_q <= '0;
            sym_cnt_q  <= '0;
            if (req_valid && ready_q) begin
              if (req_illegal) begin
                err_q <= 1'b1;
              end else begin
                state_q <= DLE1;
                type_q  <= req_type_e'(req_type);
                addr_q  <= req_addr;
                len_q   <= req_len;
                lse_q   <= req_lse;
                trans_q <= {1'b1, DLE_SYM, 1'b0};
                ready_q <= 1'b0;
              end
            end
          end
          default: begin
            if ((state_q == CLSE || state_q == ETX) && sym_cnt_q == SYM_PRE) sent_q <= 1'b1;
            if (sym_last) begin
              sym_cnt_q  <= '0;
              state_q    <= state_d;
              byte_idx_q <= idx_d;
              if (stuff_req) ret_q <= goto_s;
              if (state_d == IDLE) begin
                trans_q <= 10'h3FF;
                ready_q <= 1'b1;
              end else begin
                trans_q <= {1'b1, nxt_byte, 1'b0};
              end
            end else begin
              sym_cnt_q <= sym_cnt_q + SYM_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign trans          = trans_q;
  assign req_ready      = ready_q;
  assign trans_sent     = sent_q;
  assign req_err        = err_q;
  assign disconnected_s = (state_q == DISCONNECT);

endmodule

// File: tb/tb_sb_trans_gen.sv
// Bench for sb_trans_gen: expected frame lists are built from the framing
// rules (byte list, CRC over unstuffed bytes, then DLE insertion).
module tb_sb_trans_gen;

  localparam int MAXB = 16;
  localparam int SYM  = 8;

  logic         sb_clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_type = '0;
  logic [7:0]   req_addr = '0;
  logic [6:0]   req_len = '0;
  logic         req_lse = 1'b0;
  logic [127:0] payload = '0;
  logic         disconnect_sbtx = 1'b0;
  logic         tdisconnect_tx_min = 1'b0;
  logic [9:0]   trans;
  logic         trans_sent;
  logic         req_err;
  logic         disconnected_s;

  int checks = 0;
  int errors = 0;
  logic [7:0]  pl [MAXB];
  logic [9:0]  exp_q [$];
  logic [15:0] last_crc;

  always #5 sb_clk = ~sb_clk;

  sb_trans_gen #(.MAX_DATA_BYTES(MAXB), .SYM_CYCLES(SYM), .LEN_W(7)) dut (
    .sb_clk             (sb_clk),
    .rst                (rst),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_type           (req_type),
    .req_addr           (req_addr),
    .req_len            (req_len),
    .req_lse            (req_lse),
    .payload            (payload),
    .disconnect_sbtx    (disconnect_sbtx),
    .tdisconnect_tx_min (tdisconnect_tx_min),
    .trans              (trans),
    .trans_sent         (trans_sent),
    .req_err            (req_err),
    .disconnected_s     (disconnected_s)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] fr(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Bit-serial long division of the message by x^16+x^15+x^2+1.
  function automatic logic [15:0] crc_ref(input logic [7:0] m [$]);
    logic [15:0] r;
    logic        top;
    r = 16'hFFFF;
    foreach (m[k]) begin
      for (int b = 7; b >= 0; b--) begin
        top = r[15] ^ m[k][b];
        r   = {r[14:0], 1'b0};
        if (top) r = r ^ 16'h8005;
      end
    end
    return r;
  endfunction

  task automatic build(input int typ, input logic [7:0] addr, input int len, input bit lse);
    logic [7:0] body [$];
    logic [7:0] b;
    int nd;
    exp_q.delete();
    exp_q.push_back(fr(8'hFE));
    if (typ == 0) begin
      b = lse ? 8'h0A : 8'h02;
      exp_q.push_back(fr(b));
      exp_q.push_back(fr(~b));
    end else begin
      nd = (typ == 2 || typ == 3) ? len : 0;
      body.push_back((typ <= 2) ? 8'hA0 : 8'h20);
      body.push_back(addr);
      body.push_back(8'((typ == 2 || typ == 4) ? 128 : 0) + 8'(nd));
      for (int i = 0; i < nd; i++) body.push_back(pl[i]);
      last_crc = crc_ref(body);
      body.push_back(last_crc[15:8]);
      body.push_back(last_crc[7:0]);
      foreach (body[i]) begin
        exp_q.push_back(fr(body[i]));
        if (i > 0 && body[i] == 8'hFE) exp_q.push_back(fr(8'hFE));
      end
      exp_q.push_back(fr(8'hFE));
      exp_q.push_back(fr(8'h40));
    end
  endtask

  // Present a request for one cycle, then scramble inputs to prove they were captured.
  task automatic issue(input int typ, input logic [7:0] addr, input int len, input bit lse);
    req_type = 3'(typ);
    req_addr = addr;
    req_len  = 7'(len);
    req_lse  = lse;
    for (int i = 0; i < MAXB; i++) payload[8*i +: 8] = pl[i];
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_type  = 3'($urandom_range(0, 7));
    req_addr  = 8'($urandom);
    req_len   = 7'($urandom);
    req_lse   = 1'($urandom);
    payload   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < SYM; c++) begin
        chk($sformatf("trans f%0d c%0d", f, c), trans, exp_q[f]);
        chk("trans_sent", trans_sent, (f == exp_q.size() - 1 && c == SYM - 1));
        chk("req_ready_busy", req_ready, 0);
        step();
      end
    end
  endtask

  task automatic do_trans(input int typ, input logic [7:0] addr, input int len, input bit lse);
    build(typ, addr, len, lse);
    issue(typ, addr, len, lse);
    run_frames(exp_q.size());
    chk("idle_trans", trans, 10'h3FF);
    chk("idle_ready", req_ready, 1);
    chk("idle_sent", trans_sent, 0);
  endtask

  task automatic bad_req(input int typ, input int len);
    req_type  = 3'(typ);
    req_len   = 7'(len);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("req_err_pulse", req_err, 1);
    chk("err_trans", trans, 10'h3FF);
    chk("err_ready", req_ready, 1);
    step();
    chk("req_err_clear", req_err, 0);
    chk("err_trans2", trans, 10'h3FF);
    chk("err_ready2", req_ready, 1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < MAXB; i++) pl[i] = 8'h00;

    step();
    chk("rst_trans", trans, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_sent", trans_sent, 0);
    chk("rst_err", req_err, 0);
    chk("rst_disc", disconnected_s, 1);
    step();
    rst = 1'b1;
    chk("disc_trans", trans, 0);
    step();
    chk("idle_trans0", trans, 10'h3FF);
    chk("idle_ready0", req_ready, 1);
    chk("idle_disc0", disconnected_s, 0);

    // LT with lane select set
    do_trans(0, 8'h00, 0, 1'b1);

    // AT read command
    do_trans(1, 8'h0C, 0, 1'b0);

    // AT read response with a DLE-valued data byte
    pl[0] = 8'h11; pl[1] = 8'hFE; pl[2] = 8'h33;
    do_trans(3, 8'h05, 3, 1'b0);

    bad_req(3, 0);
    bad_req(7, 4);
    bad_req(2, MAXB + 1);

    for (int n = 0; n < 24; n++) begin
      int typ, len;
      logic [7:0] addr;
      typ  = (n < 2) ? 2 + n : int'($urandom_range(0, 4));
      len  = (n == 0) ? MAXB : (n == 1) ? 1 : int'($urandom_range(1, MAXB));
      addr = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      for (int i = 0; i < MAXB; i++) pl[i] = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      do_trans(typ, addr, len, 1'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        step();
        chk("gap_trans", trans, 10'h3FF);
      end
    end

    // Disconnect during DATA
    for (int i = 0; i < MAXB; i++) pl[i] = 8'(i + 1);
    build(2, 8'h01, 8, 1'b0);
    issue(2, 8'h01, 8, 1'b0);
    run_frames(6);
    disconnect_sbtx    = 1'b1;
    tdisconnect_tx_min = 1'b1;
    step();
    chk("disc_masked_trans", trans, exp_q[6]);
    chk("disc_masked_flag", disconnected_s, 0);
    tdisconnect_tx_min = 1'b0;
    step();
    chk("abort_trans", trans, 0);
    chk("abort_disc", disconnected_s, 1);
    chk("abort_ready", req_ready, 0);
    chk("abort_sent", trans_sent, 0);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("hold_trans", trans, 0);
      chk("hold_sent", trans_sent, 0);
    end
    disconnect_sbtx = 1'b0;
    step();
    chk("reconn_trans", trans, 10'h3FF);
    chk("reconn_ready", req_ready, 1);
    chk("reconn_disc", disconnected_s, 0);
    do_trans(0, 8'h00, 0, 1'b0);

    // Async reset in the middle of CRC_L
    build(1, 8'h0C, 0, 1'b0);
    issue(1, 8'h0C, 0, 1'b0);
    k = exp_q.size() - 3 - ((last_crc[7:0] == 8'hFE) ? 1 : 0);
    run_frames(k);
    for (int c = 0; c < 3; c++) begin
      chk("crcl_trans", trans, exp_q[k]);
      step();
    end
    rst = 1'b0;
    #1;
    chk("arst_trans", trans, 0);
    chk("arst_ready", req_ready, 0);
    chk("arst_sent", trans_sent, 0);
    chk("arst_err", req_err, 0);
    chk("arst_disc", disconnected_s, 1);
    step();
    chk("arst_hold", trans, 0);
    rst = 1'b1;
    chk("arst_rel_trans", trans, 0);
    step();
    chk("arst_idle_trans", trans, 10'h3FF);
    chk("arst_idle_ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
